// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants and types for the seven-segment number display driver.
//   - Active-low segment constants (bit 7 = DP, bits 6:0 = g..a)
//   - Glyph table for nibbles 0-9 and A-F
//   - FSM state enum
//   - pow10() used for the decimal overflow threshold
// Optional feature macro used by the design: SEVEN_SEG_HEX_MODE_EN
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Glyphs with DP off (bit 7 high); index = nibble value
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// -----------------------------------------------------------------------------
// seven_seg_glyph
// Combinational nibble-to-segment decoder for one digit.
// Ports:
//   i_nibble  digit value 0..15
//   i_blank   force the digit dark
//   i_dp      light the decimal point
//   i_hex     allow A-F glyphs; otherwise nibbles 10-15 decode to blank
//   o_seg     active-low pattern, bit 7 = DP, bits 6:0 = g..a
// -----------------------------------------------------------------------------
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_dp,
    input  logic       i_hex,
    output logic [7:0] o_seg
);

    logic [7:0] w_base;

    always_comb begin
        w_base = GLYPH[i_nibble];
        if (i_blank || (i_nibble > 4'd9 && !i_hex)) begin
            w_base = SEG_BLANK;
        end
        o_seg = {w_base[7] & ~i_dp, w_base[6:0]};
    end

endmodule

// File: rtl/seven_seg_number_display.sv
// -----------------------------------------------------------------------------
// seven_seg_number_display
// Converts an unsigned binary value to decimal with an iterative double-dabble
// engine and drives NUM_DIGITS non-multiplexed active-low seven-segment digits,
// with leading-zero blanking, overflow dashes and a decimal-point position.
// Optional macro SEVEN_SEG_HEX_MODE_EN adds a hex_mode input that bypasses the
// conversion and shows raw hex nibbles.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid/ready input handshake (ready only while idle)
//   in_value       binary value to display
//   in_dp_pos      digit index whose DP lights (>= NUM_DIGITS: none)
//   hex_mode       (macro only) show hex instead of decimal
//   disp_busy      conversion in progress
//   disp_update    one-cycle pulse when seg_out takes a new frame
//   seg_out        digit i at bits [8i+7:8i], active low
// -----------------------------------------------------------------------------
module seven_seg_number_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_WIDTH-1:0]    in_value,
    input  logic [3:0]              in_dp_pos,
`ifdef SEVEN_SEG_HEX_MODE_EN
    input  logic                    hex_mode,
`endif
    output logic                    disp_busy,
    output logic                    disp_update,
    output logic [8*NUM_DIGITS-1:0] seg_out
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    state_t                  r_state, w_next;
    logic [BIN_WIDTH-1:0]    r_bin;
    logic [BCD_W-1:0]        r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_dp;
    logic                    r_ovf;
    logic                    r_hex;
    logic [8*NUM_DIGITS-1:0] r_seg;
    logic                    r_update;

    logic                    w_accept;
    logic                    w_hex_req;
    logic [63:0]             w_val64;
    logic                    w_ovf_req;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_dp_on;
    logic [8*NUM_DIGITS-1:0] w_seg_fmt;

`ifdef SEVEN_SEG_HEX_MODE_EN
    assign w_hex_req = hex_mode;
`else
    assign w_hex_req = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_val64  = 64'(in_value);

    // Overflow is decided once at handshake from the full binary value, since the
    // BCD register may be narrower than the value's decimal width; truncated upper
    // digits never disturb lower ones because double-dabble carries only upward.
    assign w_ovf_req = w_hex_req ? ((w_val64 >> BCD_W) != 64'd0)
                                 : (w_val64 >= pow10(NUM_DIGITS));

    // Double-dabble correction: nibbles >= 5 get +3 before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Blanking: a digit goes dark only if it and everything above it are zero,
    // it is not the units digit, and it is not at or below a visible DP.
    always_comb begin
        logic v_zero_above;
        logic v_dp_valid;
        v_zero_above = 1'b1;
        v_dp_valid   = (32'(r_dp) < NUM_DIGITS);
        w_blank      = '0;
        w_dp_on      = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            v_zero_above = v_zero_above && (r_bcd[4*d +: 4] == 4'd0);
            w_blank[d]   = (LZ_BLANK != 0) && (d != 0) && v_zero_above &&
                           !(v_dp_valid && (d <= 32'(r_dp)));
            w_dp_on[d]   = v_dp_valid && (32'(r_dp) == d);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seven_seg_glyph u_glyph (
            .i_nibble (r_bcd[4*g +: 4]),
            .i_blank  (w_blank[g]),
            .i_dp     (w_dp_on[g]),
            .i_hex    (r_hex),
            .o_seg    (w_seg_fmt[8*g +: 8])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_hex_req ? ST_FORMAT : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = ST_FORMAT;
                end
            end
            ST_FORMAT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready    = (r_state == ST_IDLE);
        disp_busy   = (r_state != ST_IDLE);
        disp_update = r_update;
        seg_out     = r_seg;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_dp     <= '0;
            r_ovf    <= 1'b0;
            r_hex    <= 1'b0;
            r_seg    <= {NUM_DIGITS{SEG_BLANK}};
            r_update <= 1'b0;
        end else begin
            r_update <= (r_state == ST_FORMAT);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bin <= in_value;
                        r_dp  <= in_dp_pos;
                        r_ovf <= w_ovf_req;
                        r_hex <= w_hex_req;
                        r_cnt <= CNT_W'(BIN_WIDTH);
                        r_bcd <= w_hex_req ? w_val64[BCD_W-1:0] : '0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_FORMAT: begin
                    r_seg <= r_ovf ? {NUM_DIGITS{SEG_DASH}} : w_seg_fmt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_number_display.sv
// Self-checking bench: directed frames with literal expectations plus a long
// randomized run compared every cycle against a decimal display model.
module tb_seven_seg_number_display;

    localparam int ND    = 6;
    localparam int BW    = 20;
    localparam int SEG_W = 8 * ND;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [BW-1:0]    in_value;
    logic [3:0]       in_dp_pos;
    logic             disp_busy;
    logic             disp_update;
    logic [SEG_W-1:0] seg_out;
`ifdef SEVEN_SEG_HEX_MODE_EN
    logic             hex_mode;
`endif

    seven_seg_number_display #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .LZ_BLANK   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_dp_pos   (in_dp_pos),
`ifdef SEVEN_SEG_HEX_MODE_EN
        .hex_mode    (hex_mode),
`endif
        .disp_busy   (disp_busy),
        .disp_update (disp_update),
        .seg_out     (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Decimal display model straight from the display rules
    function automatic logic [SEG_W-1:0] model(input longint v, input int dp);
        logic [7:0] tbl [10];
        logic [SEG_W-1:0] r;
        int dig [ND];
        longint lim, t;
        int msd;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        lim = 1;
        for (int i = 0; i < ND; i++) lim = lim * 10;
        if (v >= lim) return {ND{8'hBF}};
        t = v;
        msd = 0;
        for (int i = 0; i < ND; i++) begin
            dig[i] = int'(t % 10);
            t = t / 10;
            if (dig[i] != 0) msd = i;
        end
        for (int i = 0; i < ND; i++) begin
            logic [7:0] g;
            if (i <= msd || (dp < ND && i <= dp)) g = tbl[dig[i]];
            else g = 8'hFF;
            if (dp < ND && dp == i) g = g & 8'h7F;
            r[8*i +: 8] = g;
        end
        return r;
    endfunction

    // Cycle model: countdown until the pending frame appears
    logic             m_known = 1'b0;
    int               m_cnt   = 0;
    logic             m_upd   = 1'b0;
    logic [SEG_W-1:0] m_seg   = '1;
    logic [SEG_W-1:0] m_pend  = '1;

    always @(negedge clk) begin
        if (m_known) begin
            check("outputs",
                  {13'd0, in_ready, disp_busy, disp_update, seg_out},
                  {13'd0, (m_cnt == 0), (m_cnt != 0), m_upd, m_seg});
        end
        if (rst) begin
            m_known = 1'b1;
            m_cnt   = 0;
            m_upd   = 1'b0;
            m_seg   = '1;
        end else if (m_cnt == 0) begin
            m_upd = 1'b0;
            if (in_valid) begin
                m_pend = model(longint'(in_value), int'(in_dp_pos));
                m_cnt  = BW + 1;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_seg = m_pend;
                m_upd = 1'b1;
            end else begin
                m_upd = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL wait_ready: in_ready still %b after %0d cycles", in_ready, n);
        end
    endtask

    task automatic send(input logic [BW-1:0] v, input logic [3:0] dp);
        wait_ready();
        in_valid  = 1'b1;
        in_value  = v;
        in_dp_pos = dp;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic show(input string name, input logic [BW-1:0] v, input logic [3:0] dp,
                        input logic [SEG_W-1:0] exp);
        send(v, dp);
        wait_ready();
        check(name, 64'(seg_out), 64'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        in_dp_pos = 4'd15;
`ifdef SEVEN_SEG_HEX_MODE_EN
        hex_mode  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("reset_seg",    64'(seg_out), 64'({ND{8'hFF}}));
        check("reset_ready",  64'(in_ready), 64'd1);
        check("reset_update", 64'(disp_update), 64'd0);

        // Model pinned to hand-computed frames
        check("model_123456", 64'(model(123456, 15)), 64'h0000_F9A4B0999282);
        check("model_42dp2",  64'(model(42, 2)),      64'h0000_FFFFFF4099A4);
        check("model_ovf",    64'(model(1000000, 1)), 64'h0000_BFBFBFBFBFBF);
        check("model_zero",   64'(model(0, 15)),      64'h0000_FFFFFFFFFFC0);

        // Latency: frame must not change before BW+1 edges after acceptance
        send(20'd123456, 4'd15);
        repeat (BW - 1) @(posedge clk);
        #1 check("latency_hold", 64'(seg_out), 64'({ND{8'hFF}}));
        wait_ready();
        check("dec_123456", 64'(seg_out), 64'h0000_F9A4B0999282);

        show("dec_42_dp2",  20'd42,      4'd2,  48'hFFFFFF4099A4);
        show("dec_ovf",     20'd1000000, 4'd1,  48'hBFBFBFBFBFBF);
        show("dec_zero",    20'd0,       4'd15, 48'hFFFFFFFFFFC0);
        show("dec_999999",  20'd999999,  4'd15, 48'h909090909090);
        show("dec_5_dp5",   20'd5,       4'd5,  48'h40C0C0C0C092);

        // Second request during SHIFT is ignored
        send(20'd123456, 4'd15);
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b1; in_value = 20'd777; in_dp_pos = 4'd15;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_ready();
        check("busy_ignored", 64'(seg_out), 64'h0000_F9A4B0999282);
        repeat (3) @(posedge clk); #1;
        check("busy_not_queued", 64'(seg_out), 64'h0000_F9A4B0999282);

        // Reset mid-conversion blanks and aborts
        send(20'd555555, 4'd15);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_seg",   64'(seg_out), 64'({ND{8'hFF}}));
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        repeat (BW + 3) @(posedge clk); #1;
        check("rst_mid_after", 64'(seg_out), 64'({ND{8'hFF}}));

        // Randomized traffic, including requests while busy and rare resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       in_value = BW'($urandom_range(0, 99));
                1:       in_value = BW'($urandom_range(999990, 1000010));
                default: in_value = BW'($urandom_range(0, (1 << BW) - 1));
            endcase
            in_dp_pos = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 599) == 0);
        end
        #0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
